// File: rtl/two_phase_rx.sv
// two_phase_rx: two-phase bundled-data receiver feeding a show-ahead valid/ready FIFO
module two_phase_rx #(
    parameter int BW_DATA     = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_reqL,
    input  logic [BW_DATA-1:0]            i_dataL,
    output logic                          o_ackL,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [BW_DATA-1:0]            o_data,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_stall
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;
    localparam logic [AW:0] DEPTH = FIFO_DEPTH;

    typedef enum logic [1:0] {IDLE, STALL, WRITE} state_t;

    state_t state, nextState;
    logic [SYNC_STAGES-1:0] syncQ;
    logic [AW:0] wPtr, rPtr;
    logic [BW_DATA-1:0] mem [FIFO_DEPTH];
    logic reqS, pending, full, push, pop;

    assign reqS    = syncQ[SYNC_STAGES-1];
    assign pending = reqS != o_ackL;
    assign o_count = wPtr - rPtr;
    assign full    = o_count == DEPTH;
    assign o_valid = o_count != '0;
    assign pop     = o_valid & i_ready;
    assign o_data  = o_valid ? mem[rPtr[AW-1:0]] : '0;

    // request synchroniser: only the last stage is ever looked at
    always_ff @(posedge i_clk) begin
        if (i_rst) syncQ <= '0;
        else       syncQ <= {syncQ[SYNC_STAGES-2:0], i_reqL};
    end

    // handshake state register
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= nextState;
    end

    // capture a word only when there is room; stall otherwise
    always_comb begin
        nextState = state;
        push      = 1'b0;
        o_stall   = 1'b0;
        case (state)
            IDLE:    if (pending) nextState = full ? STALL : WRITE;
            STALL: begin
                o_stall = 1'b1;
                if (!full) nextState = WRITE;
            end
            WRITE: begin
                push      = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // pointers carry a wrap bit so occupancy is their difference; ack toggles per push
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wPtr   <= '0;
            rPtr   <= '0;
            o_ackL <= 1'b0;
        end else begin
            if (push) wPtr <= wPtr + PTR_ONE;
            if (pop)  rPtr <= rPtr + PTR_ONE;
            if (push) o_ackL <= ~o_ackL;
        end
    end

    // storage needs no reset: o_valid masks stale entries
    always_ff @(posedge i_clk) begin
        if (push) mem[wPtr[AW-1:0]] <= i_dataL;
    end
endmodule

// File: tb/tb_two_phase_rx.sv
// tb_two_phase_rx: directed table and sequence checks for two_phase_rx
module tb_two_phase_rx;
    logic i_clk = 1'b0, i_rst = 1'b0, i_reqL = 1'b0, i_ready = 1'b0;
    logic [31:0] i_dataL = '0;
    logic o_ackL, o_valid, o_stall;
    logic [31:0] o_data;
    logic [2:0] o_count;

    int nChecks = 0, nFail = 0;
    logic [31:0] rxQ [$];
    int maxCount = 0, expCount = 0;
    logic trackMax = 1'b0, modelOn = 1'b0, randOn = 1'b0, lastAck = 1'b0, lastPop = 1'b0;

    typedef struct {
        logic        isPush;
        logic [31:0] data;
        logic [31:0] expCount;
        logic [31:0] expValid;
        logic [31:0] expHead;
    } vec_t;
    vec_t tbl [6];

    two_phase_rx #(.BW_DATA(32), .SYNC_STAGES(2), .FIFO_DEPTH(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_reqL(i_reqL), .i_dataL(i_dataL),
        .o_ackL(o_ackL), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
        .o_count(o_count), .o_stall(o_stall)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // pops are recorded at the edge where they happen; occupancy is modelled from acks and pops
    always @(posedge i_clk) begin
        if (!i_rst && o_valid && i_ready) rxQ.push_back(o_data);
        if (trackMax && int'(o_count) > maxCount) maxCount = int'(o_count);
        if (modelOn) begin
            expCount = expCount + ((o_ackL != lastAck) ? 1 : 0) - (lastPop ? 1 : 0);
            check("model_count", 32'(o_count), 32'(expCount));
            lastAck = o_ackL;
            lastPop = o_valid && i_ready;
        end
    end

    // random downstream readiness for the wrap test
    always @(negedge i_clk) if (randOn) i_ready = 1'($urandom_range(0, 1));

    task automatic doReset();
        @(negedge i_clk);
        i_rst = 1'b1;
        i_reqL = 1'b0;
        i_ready = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        rxQ.delete();
    endtask

    task automatic toggleReq(input logic [31:0] d);
        @(negedge i_clk);
        i_dataL = d;
        i_reqL = ~i_reqL;
    endtask

    task automatic waitAck(input int maxCyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxCyc; i++) begin
            @(posedge i_clk);
            #1;
            if (o_ackL == i_reqL) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic popOne();
        @(negedge i_clk);
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
    endtask

    initial begin
        bit ok;
        int n;
        tbl[0] = '{1'b1, 32'hA1, 1, 1, 32'hA1};
        tbl[1] = '{1'b1, 32'hA2, 2, 1, 32'hA1};
        tbl[2] = '{1'b0, 32'h0,  1, 1, 32'hA2};
        tbl[3] = '{1'b1, 32'hA3, 2, 1, 32'hA2};
        tbl[4] = '{1'b0, 32'h0,  1, 1, 32'hA3};
        tbl[5] = '{1'b0, 32'h0,  0, 0, 32'h0};

        doReset();
        #1;
        check("rst_ack", 32'(o_ackL), 0);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_count", 32'(o_count), 0);
        check("rst_stall", 32'(o_stall), 0);
        check("rst_data", o_data, 0);

        // single transfer and latency
        i_ready = 1'b1;
        toggleReq(32'hDEADBEEF);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge i_clk);
            #1;
            n++;
            if (o_ackL) break;
        end
        check("single_latency", 32'(n), 4);
        check("single_valid", 32'(o_valid), 1);
        check("single_data", o_data, 32'hDEADBEEF);
        @(posedge i_clk);
        #1;
        check("single_drained", 32'(o_count), 0);
        check("single_valid_gone", 32'(o_valid), 0);

        // table: pushes and pops with backpressure
        doReset();
        foreach (tbl[k]) begin
            if (tbl[k].isPush) begin
                toggleReq(tbl[k].data);
                waitAck(20, ok);
                check($sformatf("tbl%0d_ack", k), 32'(ok), 1);
            end else popOne();
            check($sformatf("tbl%0d_count", k), 32'(o_count), tbl[k].expCount);
            check($sformatf("tbl%0d_valid", k), 32'(o_valid), tbl[k].expValid);
            check($sformatf("tbl%0d_head", k), o_data, tbl[k].expHead);
        end

        // full and stall
        doReset();
        for (int k = 1; k <= 4; k++) begin
            toggleReq(32'(k));
            waitAck(20, ok);
            check($sformatf("full_ack%0d", k), 32'(ok), 1);
        end
        check("full_count", 32'(o_count), 4);
        toggleReq(32'd5);
        repeat (10) @(posedge i_clk);
        #1;
        check("full_stall", 32'(o_stall), 1);
        check("full_ack_frozen", 32'(o_ackL), 0);
        check("full_count_held", 32'(o_count), 4);
        check("full_head1", o_data, 1);
        popOne();
        waitAck(20, ok);
        check("full_ack5", 32'(ok), 1);
        check("full_count_after", 32'(o_count), 4);
        check("full_stall_clear", 32'(o_stall), 0);
        for (int e = 2; e <= 5; e++) begin
            check($sformatf("full_order%0d", e), o_data, 32'(e));
            popOne();
        end
        check("full_empty", 32'(o_count), 0);

        // back-to-back with downstream always ready
        doReset();
        i_ready = 1'b1;
        maxCount = 0;
        trackMax = 1'b1;
        for (int v = 'h10; v <= 'h1F; v++) begin
            toggleReq(32'(v));
            waitAck(20, ok);
            check("b2b_ack", 32'(ok), 1);
        end
        repeat (3) @(posedge i_clk);
        #1;
        trackMax = 1'b0;
        check("b2b_maxcount", 32'(maxCount <= 1), 1);
        check("b2b_len", 32'(rxQ.size()), 16);
        for (int v = 0; v < 16 && v < rxQ.size(); v++)
            check($sformatf("b2b_word%0d", v), rxQ[v], 32'(v + 'h10));

        // pointer wrap with random readiness and a cycle-by-cycle occupancy model
        doReset();
        @(negedge i_clk);
        expCount = 0;
        lastAck = 1'b0;
        lastPop = 1'b0;
        modelOn = 1'b1;
        randOn = 1'b1;
        for (int k = 0; k < 13; k++) begin
            toggleReq(32'h100 + 32'(k));
            waitAck(200, ok);
            check("wrap_ack", 32'(ok), 1);
        end
        randOn = 1'b0;
        @(negedge i_clk);
        i_ready = 1'b1;
        for (int i = 0; i < 50 && o_count != 0; i++) @(negedge i_clk);
        check("wrap_drained", 32'(o_count), 0);
        modelOn = 1'b0;
        check("wrap_len", 32'(rxQ.size()), 13);
        for (int k = 0; k < 13 && k < rxQ.size(); k++)
            check($sformatf("wrap_word%0d", k), rxQ[k], 32'h100 + 32'(k));

        // reset with a partly full FIFO and a request pending
        doReset();
        for (int k = 0; k < 3; k++) begin
            toggleReq(32'h200 + 32'(k));
            waitAck(20, ok);
        end
        check("mid_count3", 32'(o_count), 3);
        toggleReq(32'h203);
        @(negedge i_clk);
        i_rst = 1'b1;
        i_reqL = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("mid_ack", 32'(o_ackL), 0);
        check("mid_valid", 32'(o_valid), 0);
        check("mid_count", 32'(o_count), 0);
        check("mid_stall", 32'(o_stall), 0);
        toggleReq(32'hCAFE);
        waitAck(20, ok);
        check("mid_fresh_ack", 32'(ok), 1);
        check("mid_fresh_count", 32'(o_count), 1);
        check("mid_fresh_data", o_data, 32'hCAFE);

        // one toggle held for 50 cycles yields exactly one capture
        doReset();
        toggleReq(32'h77);
        n = 0;
        lastAck = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge i_clk);
            #1;
            if (o_ackL != lastAck) n++;
            lastAck = o_ackL;
        end
        check("once_toggles", 32'(n), 1);
        check("once_count", 32'(o_count), 1);
        check("once_data", o_data, 32'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
